// File: rtl/wirelog_pkg.sv
// Shared types and helpers for the wire-logic lamp bank: the FSM state,
// the default lamp pattern and the minimum-one clog2 used for index widths.
package wirelog_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMMIT  = 2'd1,
        NOTIFY  = 2'd2
    } lamp_state_e;

    localparam logic [31:0] INIT_STATE_DEFAULT = 32'h0;
    localparam int          DUP_CNT_W_DEFAULT  = 8;

    // A single lamp still needs a one-bit index bus.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/logic_lamp_bank_if.sv
// Wire-trigger handshake between the event router (master) and the lamp bank (slave).
interface logic_lamp_bank_if #(
    parameter int IDX_W = 1
) ();

    logic             trig_valid;
    logic [IDX_W-1:0] trig_idx;
    logic             trig_ready;

    modport master (
        output trig_valid,
        output trig_idx,
        input  trig_ready
    );

    modport slave (
        input  trig_valid,
        input  trig_idx,
        output trig_ready
    );

endinterface

// File: rtl/lamp_pending_accum.sv
// Collects lamp toggles for one logic step, rejecting repeats and out-of-range
// indices; the duplicate counter and index error survive clear_i.
module lamp_pending_accum
    import wirelog_pkg::*;
#(
    parameter int LAMP_COUNT = 2,
    parameter int IDX_W      = clog2_min1(LAMP_COUNT),
    parameter int DUP_CNT_W  = DUP_CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [LAMP_COUNT-1:0] pending_o,
    output logic [DUP_CNT_W-1:0]  dup_count_o,
    output logic                  idx_err_o
);

    logic [LAMP_COUNT-1:0] pending_q, pending_d;
    logic [LAMP_COUNT-1:0] hit_mask;
    logic [DUP_CNT_W-1:0]  dup_q, dup_d;
    logic                  idx_err_q, idx_err_d;
    logic                  in_range;
    logic                  is_dup;

    // Out-of-range indices decode to an empty mask so they can never alias a lamp.
    always_comb begin
        in_range = (32'(idx_i) < 32'(LAMP_COUNT));
        hit_mask = in_range ? (LAMP_COUNT'(1) << idx_i) : '0;
        is_dup   = |(pending_q & hit_mask);
    end

    always_comb begin
        pending_d = pending_q;
        dup_d     = dup_q;
        idx_err_d = idx_err_q;
        if (clear_i) begin
            pending_d = '0;
        end else if (accept_i) begin
            if (!in_range) begin
                idx_err_d = 1'b1;
            end else if (is_dup) begin
                dup_d = (dup_q == {DUP_CNT_W{1'b1}}) ? dup_q : dup_q + DUP_CNT_W'(1);
            end else begin
                pending_d = pending_q | hit_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            dup_q     <= '0;
            idx_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dup_q     <= dup_d;
            idx_err_q <= idx_err_d;
        end
    end

    assign pending_o   = pending_q;
    assign dup_count_o = dup_q;
    assign idx_err_o   = idx_err_q;

endmodule

// File: rtl/logic_lamp_bank.sv
// Lamp-state writer for a multi-input fault gate: gathers toggles per logic step,
// commits them atomically and strobes fault_pulse once the new lamps are stable.
module logic_lamp_bank
    import wirelog_pkg::*;
#(
    parameter int                    LAMP_COUNT = 2,
    parameter logic [LAMP_COUNT-1:0] INIT_STATE = LAMP_COUNT'(INIT_STATE_DEFAULT),
    parameter int                    DUP_CNT_W  = DUP_CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  logic_reset,
    input  logic                  step,
    logic_lamp_bank_if.slave      trig_if,
    output logic [LAMP_COUNT-1:0] lamp_out,
    output logic                  fault_pulse,
    output logic [DUP_CNT_W-1:0]  dup_count,
    output logic                  idx_err
);

    localparam int IDX_W = clog2_min1(LAMP_COUNT);

    lamp_state_e           state_q, state_d;
    logic [LAMP_COUNT-1:0] lamp_q, lamp_d;
    logic [LAMP_COUNT-1:0] pending;
    logic                  changed_q, changed_d;
    logic                  ready;
    logic                  accept;
    logic                  clear_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Steps seen outside COLLECT are ignored; logic_reset always wins.
    always_comb begin
        state_d = state_q;
        if (logic_reset) begin
            state_d = COLLECT;
        end else begin
            unique case (state_q)
                COLLECT: if (step) state_d = COMMIT;
                COMMIT:  state_d = NOTIFY;
                NOTIFY:  state_d = COLLECT;
                default: state_d = COLLECT;
            endcase
        end
    end

    // changed_q is only ever set leaving COMMIT, so it is high solely during NOTIFY.
    always_comb begin
        ready         = (state_q == COLLECT);
        accept        = trig_if.trig_valid & ready & ~logic_reset;
        clear_pending = logic_reset | (state_q == COMMIT);
        lamp_d        = lamp_q;
        changed_d     = 1'b0;
        if (logic_reset) begin
            lamp_d = INIT_STATE;
        end else if (state_q == COMMIT) begin
            lamp_d    = lamp_q ^ pending;
            changed_d = |pending;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamp_q    <= INIT_STATE;
            changed_q <= 1'b0;
        end else begin
            lamp_q    <= lamp_d;
            changed_q <= changed_d;
        end
    end

    lamp_pending_accum #(
        .LAMP_COUNT (LAMP_COUNT),
        .IDX_W      (IDX_W),
        .DUP_CNT_W  (DUP_CNT_W)
    ) u_accum (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (clear_pending),
        .accept_i    (accept),
        .idx_i       (trig_if.trig_idx),
        .pending_o   (pending),
        .dup_count_o (dup_count),
        .idx_err_o   (idx_err)
    );

    assign trig_if.trig_ready = ready;
    assign lamp_out           = lamp_q;
    assign fault_pulse        = changed_q;

endmodule
